health_manager: RTL
===================

Name: health_manager

Overview:
Parametrised successor to the single-ship health register. Tracks health for NUM_SHIPS ships, each with:
- multi-point damage and healing
- saturating arithmetic
- a post-hit invulnerability window
- a death flag and one-cycle death event

It also produces a sticky game_over flag when every ship is dead. It sits between the collision/pickup logic and the HUD/game-state FSM.

Parameters:
NUM_SHIPS, 2, number of independent ship channels (>=1)
HEALTH_W, 4, width of each health value and each damage/heal amount
MAX_HEALTH, 15, full-health value loaded at reset/start; 1 <= MAX_HEALTH <= 2^HEALTH_W-1
INVULN_CYCLES, 8, clk cycles of damage immunity after a surviving hit; 0 disables invulnerability

Ports:
clk  in  1  system clock (50 MHz on board)
reset  in  1  asynchronous, active-high reset
start_game  in  1  synchronous re-initialisation of all channels
hit  in  NUM_SHIPS  per-ship damage strobe
hit_amount  in  NUM_SHIPS*HEALTH_W  damage for ship i at [i*HEALTH_W +: HEALTH_W]
heal  in  NUM_SHIPS  per-ship heal strobe
heal_amount  in  NUM_SHIPS*HEALTH_W  heal for ship i, same packing
ship_health  out  NUM_SHIPS*HEALTH_W  registered health, same packing
invuln  out  NUM_SHIPS  ship i currently immune to damage
dead  out  NUM_SHIPS  ship i health reached 0
death_pulse  out  NUM_SHIPS  one-cycle pulse on the cycle dead[i] rises
game_over  out  1  all ships dead; sticky

Behaviour:
Interface
- Single clock domain: clk.
- reset is asynchronous and active-high.
- All outputs are registered.

Reset
- While reset is high, and on the first edge after it: every ship_health = MAX_HEALTH, state ALIVE, timers 0.
- invuln = 0, dead = 0, death_pulse = 0, game_over = 0.

start_game
- Highest synchronous priority. When high at edge n, from cycle n+1 the outputs equal the reset values.
- All hit/heal strobes at edge n are ignored.

Per-ship FSM (channels independent)
- States: ALIVE, INVULN, DEAD.
- Strobes are sampled at edge n; results are visible from cycle n+1 (1-cycle latency).
- A strobe with amount 0 is ignored (no state change, no invulnerability).

ALIVE state
- Compute next = health + (heal ? heal_amount : 0) - (hit ? hit_amount : 0) in signed HEALTH_W+2 bits.
- next <= 0: health = 0, go to DEAD, death_pulse = 1 for exactly one cycle.
- next > MAX_HEALTH: health saturates to MAX_HEALTH.
- Effective nonzero hit and survival, with INVULN_CYCLES > 0: go to INVULN and load timer = INVULN_CYCLES.
- Effective nonzero hit and survival, with INVULN_CYCLES = 0: stay ALIVE.
- Heal only: stay ALIVE.

INVULN state
- invuln = 1.
- hit is ignored. heal is applied with saturation at MAX_HEALTH.
- Timer decrements every cycle. When it reaches 0, go to ALIVE.
- invuln is high for exactly INVULN_CYCLES cycles (cycles n+1 .. n+INVULN_CYCLES).
- A hit at edge n+INVULN_CYCLES+1 is accepted.
- A new hit does not retrigger the timer.

DEAD state
- hit and heal are ignored. health stays 0. dead = 1.
- Exit only via start_game or reset.

game_over
- Set in the same cycle the last dead bit rises, computed from next-state.
- Simultaneous deaths count.
- Held until start_game or reset.

Reset mid-operation
- Asynchronous reset from any state immediately forces all reset values, including in-flight timers and death_pulse.

Width rules
- Amounts are unsigned.
- hit_amount >= health is lethal even when it exceeds MAX_HEALTH.
- Intermediate arithmetic never wraps.

Test Plan:
1. Reset, then hit[0]=1, hit_amount[0]=3 for one cycle -> ship_health[0]=12 next cycle; invuln[0]=1 for exactly 8 cycles; ship 1 stays 15.
2. During invuln, hit[0] amount 5, then heal[0] amount 2 -> hit ignored; health 12->14. After invuln drops, hit amount 1 -> health 13, invuln re-asserts.
3. Health 13, simultaneous hit 2 and heal 5 -> health 15 (saturated), invuln=1. In a separate case, health 4 with hit 3 and heal 0 -> health 1.
4. Health 2, hit amount 9 -> health 0, dead[0]=1, death_pulse[0] high one cycle, invuln[0]=0. Later hits and heals to ship 0 leave health at 0.
5. Ship 0 dead; ship 1 lethal hit -> game_over=1 with dead[1]. Then start_game together with a hit -> all health 15, dead=0, game_over=0, hit ignored.
6. Assert reset asynchronously mid-invuln with timer=5 -> outputs return to reset values before the next edge. INVULN_CYCLES=0 build: consecutive hits of 1 each cycle decrement health every cycle.

Source files
------------

// File: rtl/health_manager.sv
// health_manager: per-ship health tracking with saturating damage/heal,
// post-hit invulnerability, death flag/pulse and a sticky game_over flag.
module health_manager #(
    parameter int unsigned NUM_SHIPS     = 2,
    parameter int unsigned HEALTH_W      = 4,
    parameter int unsigned MAX_HEALTH    = 15,
    parameter int unsigned INVULN_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_game,
    input  logic [NUM_SHIPS-1:0]          hit,
    input  logic [NUM_SHIPS*HEALTH_W-1:0] hit_amount,
    input  logic [NUM_SHIPS-1:0]          heal,
    input  logic [NUM_SHIPS*HEALTH_W-1:0] heal_amount,
    output logic [NUM_SHIPS*HEALTH_W-1:0] ship_health,
    output logic [NUM_SHIPS-1:0]          invuln,
    output logic [NUM_SHIPS-1:0]          dead,
    output logic [NUM_SHIPS-1:0]          death_pulse,
    output logic                          game_over
);

    // Two extra bits so health + heal - hit never wraps.
    localparam int unsigned SUM_W = HEALTH_W + 2;
    localparam int unsigned TMR_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES + 1) : 1;

    localparam logic        [HEALTH_W-1:0] MAX_H    = HEALTH_W'(MAX_HEALTH);
    localparam logic signed [SUM_W-1:0]    MAX_S    = SUM_W'(MAX_HEALTH);
    localparam logic        [SUM_W-1:0]    MAX_U    = SUM_W'(MAX_HEALTH);
    localparam logic        [TMR_W-1:0]    TMR_LOAD = TMR_W'(INVULN_CYCLES);
    localparam logic        [TMR_W-1:0]    TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } ship_state_e;

    // Next-cycle dead flags of all ships, used for same-cycle game_over.
    logic [NUM_SHIPS-1:0] dead_d;

    for (genvar i = 0; i < NUM_SHIPS; i++) begin : g_ship
        ship_state_e             state_q, state_d;
        logic [HEALTH_W-1:0]     health_q, health_d;
        logic [TMR_W-1:0]        timer_q, timer_d;
        logic [HEALTH_W-1:0]     hit_amt, heal_amt;
        logic                    hit_eff, heal_eff;
        logic signed [SUM_W-1:0] sum;
        logic [SUM_W-1:0]        heal_sum;
        logic                    invuln_q, dead_q, pulse_q;

        assign hit_amt  = hit_amount[i*HEALTH_W +: HEALTH_W];
        assign heal_amt = heal_amount[i*HEALTH_W +: HEALTH_W];
        assign hit_eff  = hit[i] && (hit_amt != '0);
        assign heal_eff = heal[i] && (heal_amt != '0);

        // Net health after this cycle's strobes, and heal-only sum for INVULN.
        assign sum = $signed(SUM_W'(health_q)
                             + (heal_eff ? SUM_W'(heal_amt) : SUM_W'(0))
                             - (hit_eff ? SUM_W'(hit_amt) : SUM_W'(0)));
        assign heal_sum = SUM_W'(health_q) + (heal_eff ? SUM_W'(heal_amt) : SUM_W'(0));

        // Next-state and next-health logic for one ship.
        always_comb begin
            state_d  = state_q;
            health_d = health_q;
            timer_d  = timer_q;
            unique case (state_q)
                ALIVE: begin
                    if (hit_eff || heal_eff) begin
                        if (sum[SUM_W-1] || (sum == '0)) begin
                            health_d = '0;
                            state_d  = DEAD;
                        end else begin
                            health_d = (sum > MAX_S) ? MAX_H : HEALTH_W'(sum);
                            if (hit_eff && (INVULN_CYCLES != 0)) begin
                                state_d = INVULN;
                                timer_d = TMR_LOAD;
                            end
                        end
                    end
                end
                INVULN: begin
                    health_d = (heal_sum > MAX_U) ? MAX_H : HEALTH_W'(heal_sum);
                    if (timer_q <= TMR_ONE) begin
                        state_d = ALIVE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                DEAD: begin
                    health_d = '0;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
            if (start_game) begin
                state_d  = ALIVE;
                health_d = MAX_H;
                timer_d  = '0;
            end
        end

        // State, health, timer and registered status flags.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= ALIVE;
                health_q <= MAX_H;
                timer_q  <= '0;
                invuln_q <= 1'b0;
                dead_q   <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                health_q <= health_d;
                timer_q  <= timer_d;
                invuln_q <= (state_d == INVULN);
                dead_q   <= (state_d == DEAD);
                pulse_q  <= (state_d == DEAD) && (state_q != DEAD);
            end
        end

        assign dead_d[i]                           = (state_d == DEAD);
        assign ship_health[i*HEALTH_W +: HEALTH_W] = health_q;
        assign invuln[i]                           = invuln_q;
        assign dead[i]                             = dead_q;
        assign death_pulse[i]                      = pulse_q;
    end

    // Sticky game_over, set on the edge the last ship dies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_over <= 1'b0;
        end else if (start_game) begin
            game_over <= 1'b0;
        end else if (&dead_d) begin
            game_over <= 1'b1;
        end
    end

endmodule
